// File: rtl/serial_frame_collector_pkg.sv
// Shared types and constants for the serial frame collector slice.
package serial_frame_collector_pkg;

    localparam int unsigned FRAME_W = 5;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [FRAME_W-1:0] data;
        logic               parity;
    } frame_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty; push accepted when full if a pop lands on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_W-1:0]] <= push_data;
                wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/serial_frame_collector.sv
// Reassembles MSB-first serial frames, attaches even parity and queues them behind a valid/ready FIFO.
module serial_frame_collector
    import serial_frame_collector_pkg::*;
#(
    parameter int unsigned WIDTH = FRAME_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             overflow
);

    localparam int unsigned IDX_W   = $clog2(WIDTH);
    localparam int unsigned ENTRY_W = WIDTH + 1;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   bit_idx;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_shift;
    logic               last_bit;
    logic               push;
    logic               abort;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;

    assign acc_shift = {acc[WIDTH-2:0], sdata};
    assign last_bit  = (bit_idx == IDX_W'(WIDTH-1));
    assign pop       = !fifo_empty && out_ready;

    // State register; busy is registered from the next state so it tracks SHIFT exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == SHIFT);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (!start && last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A restart wins over completion, so a start on the last bit cycle never pushes.
    always_comb begin
        push  = 1'b0;
        abort = 1'b0;
        if (state == SHIFT) begin
            push  = !start && last_bit;
            abort = start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            bit_idx   <= '0;
            abort_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (start || state == SHIFT) begin
                acc <= acc_shift;
            end
            if (start) begin
                bit_idx <= IDX_W'(1);
            end else if (state == SHIFT) begin
                bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
            end
            if (abort && abort_cnt != {CNT_W{1'b1}}) begin
                abort_cnt <= abort_cnt + CNT_W'(1);
            end
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({acc_shift, ^acc_shift}),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = head[ENTRY_W-1:1];
    assign out_parity = head[0];

endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector with hand-computed frames and parities.
module tb_serial_frame_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sdata = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] out_data;
    logic       out_parity;
    logic       out_valid;
    logic       busy;
    logic [7:0] abort_cnt;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_frame_collector #(.WIDTH(5), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sdata      (sdata),
        .out_data   (out_data),
        .out_parity (out_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .abort_cnt  (abort_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_bit(input logic st, input logic d);
        start = st;
        sdata = d;
        tick();
        start = 1'b0;
    endtask

    // Sends a full frame MSB first; ready_last raises out_ready only on the final bit edge.
    task automatic send_frame(input logic [4:0] f, input logic ready_last);
        for (int i = 4; i >= 0; i--) begin
            if (i == 0) out_ready = ready_last;
            send_bit(i == 4, f[i]);
        end
        out_ready = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [4:0] d, input logic p);
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_par"}, 32'(out_parity), 32'(p));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_data"}, 32'(out_data), 32'(0));
        check({tag, "_par"}, 32'(out_parity), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_abort"}, 32'(abort_cnt), 32'(0));
        check({tag, "_ovf"}, 32'(overflow), 32'(0));
    endtask

    initial begin
        do_reset();
        check_reset_state("rst0");

        // Frame 10101 with latency checks.
        send_bit(1'b1, 1'b1);
        check("t1_busy_e0", 32'(busy), 32'(1));
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        check("t1_valid_e3", 32'(out_valid), 32'(0));
        check("t1_busy_e3", 32'(busy), 32'(1));
        send_bit(1'b0, 1'b1);
        check("t1_busy_e4", 32'(busy), 32'(0));
        pop_expect("t1", 5'b10101, 1'b1);
        check("t1_empty", 32'(out_valid), 32'(0));

        // Back-to-back frames, no gap.
        send_frame(5'b11111, 1'b0);
        send_frame(5'b00110, 1'b0);
        pop_expect("t2a", 5'b11111, 1'b1);
        pop_expect("t2b", 5'b00110, 1'b0);
        check("t2_empty", 32'(out_valid), 32'(0));

        // Restart at bit_idx 3 of 11000, then 01111.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_frame(5'b01111, 1'b0);
        check("t3_abort", 32'(abort_cnt), 32'(1));
        pop_expect("t3", 5'b01111, 1'b0);
        check("t3_empty", 32'(out_valid), 32'(0));

        // Five frames into a 4-deep FIFO with no pops.
        do_reset();
        send_frame(5'b00001, 1'b0);
        send_frame(5'b00010, 1'b0);
        send_frame(5'b00011, 1'b0);
        send_frame(5'b00100, 1'b0);
        check("t4_ovf_pre", 32'(overflow), 32'(0));
        send_frame(5'b00101, 1'b0);
        check("t4_ovf", 32'(overflow), 32'(1));
        pop_expect("t4a", 5'b00001, 1'b1);
        pop_expect("t4b", 5'b00010, 1'b1);
        pop_expect("t4c", 5'b00011, 1'b0);
        pop_expect("t4d", 5'b00100, 1'b1);
        check("t4_empty", 32'(out_valid), 32'(0));

        // Same, but a pop coincides with the fifth push.
        do_reset();
        send_frame(5'b00001, 1'b0);
        send_frame(5'b00010, 1'b0);
        send_frame(5'b00011, 1'b0);
        send_frame(5'b00100, 1'b0);
        send_frame(5'b00101, 1'b1);
        check("t4r_ovf", 32'(overflow), 32'(0));
        pop_expect("t4r_a", 5'b00010, 1'b1);
        pop_expect("t4r_b", 5'b00011, 1'b0);
        pop_expect("t4r_c", 5'b00100, 1'b1);
        pop_expect("t4r_d", 5'b00101, 1'b0);
        check("t4r_empty", 32'(out_valid), 32'(0));

        // Asynchronous reset mid-frame with two queued entries.
        send_frame(5'b11100, 1'b0);
        send_frame(5'b00111, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("t5_busy_pre", 32'(busy), 32'(1));
        check("t5_valid_pre", 32'(out_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("t5_rst");
        rst = 1'b0;
        tick();
        send_frame(5'b10001, 1'b0);
        pop_expect("t5", 5'b10001, 1'b0);
        check("t5_empty", 32'(out_valid), 32'(0));

        // Continuous restarts: first start leaves IDLE, every later one aborts.
        for (int i = 0; i < 255; i++) send_bit(1'b1, 1'b0);
        check("t6_abort_254", 32'(abort_cnt), 32'(254));
        send_bit(1'b1, 1'b0);
        check("t6_abort_255", 32'(abort_cnt), 32'(255));
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("t6_abort_sat", 32'(abort_cnt), 32'(255));
        check("t6_no_push", 32'(out_valid), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_collector.md
# serial_frame_collector

Downstream consumer of the 5-bit left-shifting load register. It samples that register's MSB serial stream, reassembles each 5-bit frame MSB-first, and computes even parity. It buffers completed frames in a small FIFO with a valid/ready output handshake, and counts aborted frames and overflow events for debug.

## Interface
- WIDTH, 5, bits per frame (≥2)
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; marks the cycle in which bit 0 (the frame MSB) is on sdata
- sdata  in  1  serial bit (upstream Q[WIDTH-1])
- out_data  out  WIDTH  head-of-FIFO frame, first received bit in MSB
- out_parity  out  1  XOR of all bits of out_data
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready at a clock edge
- busy  out  1  collector in SHIFT state
- abort_cnt  out  8  frames abandoned by restart; saturates at 255
- overflow  out  1  sticky; set when a completed frame is dropped because the FIFO is full

## Operation
- States: IDLE and SHIFT. A bit counter bit_idx runs 0..WIDTH-1, and a shift accumulator holds the partial frame.
- IDLE & start: capture sdata as bit 0 (acc <= {acc[WIDTH-2:0], sdata}), set bit_idx=1, go to SHIFT.
- IDLE & !start: sdata is ignored.
- SHIFT & !start: shift sdata into acc and increment bit_idx. On the edge that captures bit WIDTH-1, the frame is complete:
  - push {acc shifted, parity} into the FIFO;
  - go to IDLE.
- SHIFT & start (any bit_idx, including the last bit cycle): the partial frame is discarded, with no push. abort_cnt increments (saturating). The sampled sdata becomes bit 0 of the new frame, bit_idx=1, and the state stays SHIFT.
- Parity is computed on the complete frame and stored alongside it, so out_parity always matches out_data.
- FIFO:
  - push and pop are evaluated on the same edge;
  - when full, a pop and a push on the same edge both succeed and the count is unchanged;
  - when full with no pop, the push is dropped and overflow sets;
  - when empty, the push lands and out_valid rises after the edge, with no same-cycle bypass;
  - read and write pointers wrap modulo DEPTH, with an extra bit to tell full from empty.
- When out_valid=0, out_data and out_parity show the stale head entry; consumers must ignore them.
- Reset values: state IDLE, bit_idx 0, acc 0, FIFO empty (out_valid 0, out_data 0, out_parity 0), busy 0, abort_cnt 0, overflow 0.

## Timing
- start sampled at edge E0 means bits are captured at E0..E(WIDTH-1). The push happens at E(WIDTH-1), and out_valid is high in the cycle after E(WIDTH-1). Latency from E0 to out_valid is WIDTH edges.
- busy is high from after E0 through the cycle before E(WIDTH-1) is sampled, and low after E(WIDTH-1).
- Back-to-back frames: start may be asserted in the cycle right after the last bit, with no gap cycle. This gives sustained throughput of 1 frame per WIDTH cycles.
- Upstream alignment: assert start in the cycle after the upstream LD edge, when Q holds the preset value.
- Reset mid-frame or with FIFO contents clears everything immediately, with no partial push.

## Structure
- Shared package: a FRAME_W=5 constant, the state enum {IDLE, SHIFT}, and a frame_t typedef (data plus parity).
- One natural sub-module: sync_fifo (parameters WIDTH+1, DEPTH) with push/full/pop/empty. The collector FSM, counters and parity stay in the top module.

## Test plan
- Reset then start with the serial stream 1,0,1,0,1 → one entry: out_data=5'b10101, out_parity=1, out_valid high 5 edges after start; pop with out_ready=1 → out_valid=0.
- Two back-to-back frames 11111 and 00110 with no gap, out_ready=0 → 2 entries; pops return 11111 (parity 1) then 00110 (parity 0), in order.
- start again at bit_idx=3 of frame 11000, followed by frame 01111 → abort_cnt=1, only 01111 (parity 0) is queued.
- Five complete frames with out_ready=0 → 4 entries, overflow=1, and the 5th frame is absent. Repeat with out_ready=1 on the 5th push edge → no overflow, count stays 4.
- Assert rst mid-frame with 2 FIFO entries → all outputs return to reset values; a following frame 10001 is received correctly.
- 260 aborted frames → abort_cnt holds at 255.
